// File: rtl/uart_arb_pkg.sv
// Shared state encoding, default sizing and a constant-foldable clog2 for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    GUARD = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_LOCK_TIMEOUT = 1024;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester pick: a held lock pins the owner, otherwise the first request after i_last.
// Zero latency; o_sel is one-hot or all-zero when nothing is requested and no lock is held.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IW-1:0]    i_last,
  input  logic             i_lock,
  input  logic [IW-1:0]    i_owner,
  output logic [N_REQ-1:0] o_sel,
  output logic [IW-1:0]    o_idx
);

  logic          w_found;
  logic [IW-1:0] w_j;

  always_comb begin
    o_sel   = '0;
    o_idx   = i_last;
    w_found = 1'b0;
    w_j     = '0;
    if (i_lock) begin
      o_sel[i_owner] = 1'b1;
      o_idx          = i_owner;
    end else begin
      // Walk i_last+1 .. i_last+N_REQ so the previous winner is checked last.
      for (int k = 1; k <= N_REQ; k++) begin
        w_j = IW'((int'(i_last) + k) % N_REQ);
        if (!w_found && i_req[w_j]) begin
          w_found    = 1'b1;
          o_sel[w_j] = 1'b1;
          o_idx      = w_j;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates N_REQ byte streams onto one UART engine with packet locking and an idle-lock timeout.
// tx_wr follows a handshake by one cycle; req_ready is held low outside IDLE and while tx_busy is high.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [8*N_REQ-1:0]      req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [clog2(N_REQ)-1:0] grant_id,
  output logic                    locked,
  output logic                    lock_drop,
  output logic [7:0]              tx_data,
  output logic                    tx_wr,
  input  logic                    tx_busy
);

  localparam int IW = clog2(N_REQ);
  localparam int CW = clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT - 1);

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic [7:0]       r_tx_data;
  logic [IW-1:0]    r_grant_id;
  logic             r_locked;
  logic             r_lock_drop;
  logic [CW-1:0]    r_cnt;

  logic [N_REQ-1:0] w_sel;
  logic [IW-1:0]    w_idx;
  logic [N_REQ-1:0] w_ready;
  logic             w_tx_wr;
  logic             w_hs;
  logic [7:0]       w_hs_data;
  logic             w_hs_last;
  logic             w_owner_idle;

  // grant_id doubles as the lock owner: a lock is only ever taken by the last winner.
  rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .i_req   (req_valid),
    .i_last  (r_grant_id),
    .i_lock  (r_locked),
    .i_owner (r_grant_id),
    .o_sel   (w_sel),
    .o_idx   (w_idx)
  );

  always_comb begin
    w_hs_data = '0;
    w_hs_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel[i]) begin
        w_hs_data = req_data[8*i +: 8];
        w_hs_last = req_last[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = '0;
    w_tx_wr     = 1'b0;
    case (r_state)
      IDLE: begin
        if (!tx_busy && !reset) w_ready = w_sel;
        if (|(req_valid & w_ready)) w_state_nxt = LOAD;
      end
      LOAD: begin
        w_tx_wr     = 1'b1;
        w_state_nxt = GUARD;
      end
      GUARD: w_state_nxt = DRAIN;
      DRAIN: if (!tx_busy) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_hs         = |(req_valid & w_ready);
  assign w_owner_idle = r_locked && (r_state == IDLE) && !req_valid[r_grant_id];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_data   <= '0;
      r_grant_id  <= IW'(N_REQ - 1);
      r_locked    <= 1'b0;
      r_lock_drop <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_lock_drop <= 1'b0;
      if (w_hs) begin
        r_tx_data  <= w_hs_data;
        r_grant_id <= w_idx;
        r_locked   <= !w_hs_last;
        r_cnt      <= '0;
      end else if (w_owner_idle) begin
        // grant_id is kept on a drop so the search resumes just past the stalled owner.
        if (r_cnt == TO_LAST) begin
          r_locked    <= 1'b0;
          r_lock_drop <= 1'b1;
          r_cnt       <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign tx_wr     = w_tx_wr;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign locked    = r_locked;
  assign lock_drop = r_lock_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random packet mixes against a queue-level model.
module tb_uart_tx_arbiter;

  localparam int N    = 4;
  localparam int TO   = 16;
  localparam int BUSY = 10;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           locked;
  logic           lock_drop;
  logic [7:0]     tx_data;
  logic           tx_wr;
  logic           tx_busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(
    .N_REQ        (N),
    .LOCK_TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .grant_id  (grant_id),
    .locked    (locked),
    .lock_drop (lock_drop),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_busy   (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // UART engine: busy rises the cycle after tx_wr and stays high BUSY cycles.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (tx_wr) busy_cnt <= BUSY;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: one-hot ready, write strobe only after a handshake taken with the engine idle.
  logic [10:0] log_q[$];
  bit prev_hs   = 1'b0;
  bit prev_busy = 1'b0;
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      check("onehot_ready", 32'($countones(req_ready) <= 1), 1);
      if (tx_wr) begin
        check("wr_after_hs", 32'(prev_hs), 1);
        check("wr_not_busy", 32'(prev_busy), 0);
        log_q.push_back({locked, grant_id, tx_data});
      end
    end
    prev_hs   = !reset && |(req_valid & req_ready);
    prev_busy = tx_busy;
  end

  logic [8:0]  pk [N][16];
  int          wr [N];
  int          rd [N];
  logic [10:0] exp_q[$];
  int          model_gid;

  task automatic clear_q();
    for (int i = 0; i < N; i++) begin wr[i] = 0; rd[i] = 0; end
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    pk[r][wr[r]] = {last, d};
    wr[r]++;
  endtask

  task automatic wait_idle(input string tag);
    int quiet;
    quiet = 0;
    for (int c = 0; c < 200 && quiet < 3; c++) begin
      @(negedge clk);
      quiet = tx_busy ? 0 : quiet + 1;
    end
    check({tag, "_idle"}, quiet, 3);
  endtask

  // Expected byte order from the arbitration rules alone, then drive and compare.
  task automatic run_phase(input string tag, input int budget);
    int p [N];
    int last, own, pend_cnt;
    bit lk, pend;
    exp_q.delete();
    log_q.delete();
    last = model_gid; lk = 1'b0; own = 0;
    for (int i = 0; i < N; i++) p[i] = 0;
    for (int n = 0; n < 64; n++) begin
      int w;
      w = -1;
      if (lk) w = own;
      else for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (w < 0 && p[j] < wr[j]) w = j;
      end
      if (w < 0) break;
      exp_q.push_back({~pk[w][p[w]][8], 2'(w), pk[w][p[w]][7:0]});
      lk = ~pk[w][p[w]][8]; own = w; last = w; p[w]++;
    end
    model_gid = last;

    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      pend = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (rd[i] < wr[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = pk[i][rd[i]][7:0];
          req_last[i] = pk[i][rd[i]][8];
          pend = 1'b1;
        end else begin
          req_valid[i] = 1'b0;
        end
      end
      if (!pend) break;
      #1;
      for (int i = 0; i < N; i++) if (req_valid[i] && req_ready[i]) rd[i]++;
    end
    req_valid = '0;
    pend_cnt = 0;
    for (int i = 0; i < N; i++) pend_cnt += wr[i] - rd[i];
    check({tag, "_drained"}, pend_cnt, 0);
    wait_idle(tag);
    check({tag, "_count"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 32'(log_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int drop_at, nbytes;
    // Reset state, with every requester asking so ready gating is exercised.
    reset = 1'b1; req_valid = '1; req_data = '0; req_last = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_tx_wr", 32'(tx_wr), 0);
    check("rst_grant", 32'(grant_id), N - 1);
    check("rst_locked", 32'(locked), 0);
    check("rst_drop", 32'(lock_drop), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    @(negedge clk); reset = 1'b0; req_valid = '0; model_gid = N - 1;

    // Scenario 1: single byte from requester 0.
    @(negedge clk);
    req_valid = 4'b0001; req_data[7:0] = 8'h41; req_last = 4'b0001;
    #1 check("s1_ready", 32'(req_ready), 'b0001);
    @(negedge clk); req_valid = '0;
    #1;
    check("s1_tx_wr", 32'(tx_wr), 1);
    check("s1_tx_data", 32'(tx_data), 'h41);
    check("s1_grant", 32'(grant_id), 0);
    check("s1_locked", 32'(locked), 0);
    @(negedge clk); #1 check("s1_wr_pulse", 32'(tx_wr), 0);
    wait_idle("s1");
    check("s1_hold", 32'(tx_data), 'h41);

    // Scenario 2: all four continuously valid from reset -> 0,1,2,3,0.
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0; model_gid = N - 1;
    clear_q();
    push_byte(0, 8'hA0, 1'b1); push_byte(0, 8'hA4, 1'b1);
    push_byte(1, 8'hA1, 1'b1); push_byte(2, 8'hA2, 1'b1); push_byte(3, 8'hA3, 1'b1);
    run_phase("s2", 200);

    // Scenario 3: requester 2 holds a three-byte packet against requester 0.
    clear_q();
    push_byte(2, 8'h10, 1'b0); push_byte(2, 8'h11, 1'b0); push_byte(2, 8'h12, 1'b1);
    push_byte(0, 8'h55, 1'b1);
    run_phase("s3", 200);

    // Scenario 4: requester 1 locks and goes quiet; lock must time out after TO idle cycles.
    @(negedge clk);
    req_valid = 4'b0010; req_data = '0; req_data[15:8] = 8'h21; req_last = '0;
    #1 check("s4_ready", 32'(req_ready), 'b0010);
    @(negedge clk);
    req_valid = 4'b0101; req_data = '0; req_data[7:0] = 8'h05; req_data[23:16] = 8'h32;
    req_last = 4'b0101;
    #1;
    check("s4_tx_wr", 32'(tx_wr), 1);
    check("s4_locked", 32'(locked), 1);
    check("s4_grant", 32'(grant_id), 1);
    drop_at = -1;
    for (int k = 1; k <= 40 && drop_at < 0; k++) begin
      @(negedge clk); #1;
      if (lock_drop) drop_at = k;
      else check($sformatf("s4_blocked_%0d", k), 32'(req_ready & 4'b0101), 0);
    end
    // LOAD, then GUARD plus BUSY cycles of drain, then TO idle cycles; the pulse follows.
    check("s4_drop_time", drop_at, BUSY + 2 + TO);
    check("s4_unlocked", 32'(locked), 0);
    check("s4_next_ready", 32'(req_ready), 'b0100);
    @(negedge clk); req_valid = '0;
    #1;
    check("s4_drop_pulse", 32'(lock_drop), 0);
    check("s4_tx_wr2", 32'(tx_wr), 1);
    check("s4_tx_data2", 32'(tx_data), 'h32);
    check("s4_grant2", 32'(grant_id), 2);
    wait_idle("s4");

    // Scenario 5: reset during GUARD aborts the sequence and the lock.
    @(negedge clk);
    req_valid = 4'b1000; req_data = '0; req_data[31:24] = 8'h77; req_last = '0;
    #1 check("s5_ready", 32'(req_ready), 'b1000);
    @(negedge clk); req_valid = '0;
    #1 check("s5_locked", 32'(locked), 1);
    @(negedge clk); reset = 1'b1;
    #1 check("s5_guard_wr", 32'(tx_wr), 0);
    @(negedge clk); reset = 1'b0;
    #1;
    check("s5_tx_wr", 32'(tx_wr), 0);
    check("s5_locked0", 32'(locked), 0);
    check("s5_grant", 32'(grant_id), N - 1);
    check("s5_drop", 32'(lock_drop), 0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1 check("s5_no_wr", 32'(tx_wr), 0);
    end
    wait_idle("s5");
    model_gid = N - 1;

    // Random packet mixes.
    for (int r = 0; r < 4; r++) begin
      clear_q();
      nbytes = 0;
      for (int i = 0; i < N; i++) begin
        int npk;
        npk = $urandom_range(0, 3);
        for (int pkt = 0; pkt < npk; pkt++) begin
          int len;
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) begin
            push_byte(i, 8'($urandom_range(0, 255)), b == len - 1);
            nbytes++;
          end
        end
      end
      run_phase($sformatf("rnd%0d", r), nbytes * 16 + 20);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of byte-stream requesters (2..8).
REQ-002 The block SHALL have parameter LOCK_TIMEOUT, default 1024, giving the idle cycles allowed before a packet lock is forcibly released.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port list, one per line, clock and reset first:
  clk  input  1  system clock
  reset  input  1  synchronous active-high reset
  req_valid  input  N_REQ  requester i has a byte
  req_data  input  8*N_REQ  byte of requester i at bits [8i+7:8i]
  req_last  input  N_REQ  byte is the final byte of a packet
  req_ready  output  N_REQ  byte i accepted this cycle when valid&ready
  grant_id  output  clog2(N_REQ)  index of the current or last owner
  locked  output  1  a packet lock is held
  lock_drop  output  1  one-cycle pulse on timeout release
  tx_data  output  8  byte to UART engine
  tx_wr  output  1  one-cycle write strobe to UART engine
  tx_busy  input  1  UART engine transmitting

Function
REQ-005 The state machine SHALL have states IDLE, LOAD, GUARD and DRAIN.
REQ-006 In IDLE, with tx_busy=0, the arbiter SHALL assert req_ready for exactly one requester, chosen as follows:
  - if locked, the owner;
  - otherwise the first requester with req_valid=1, searching round-robin from grant_id+1 modulo N_REQ.
REQ-007 req_ready SHALL be 0 in LOAD, GUARD and DRAIN, and whenever tx_busy=1.
REQ-008 On a handshake (req_valid[i]&req_ready[i]), the block SHALL:
  - register req_data[i] into tx_data;
  - set grant_id=i;
  - enter LOAD.
REQ-009 In LOAD, tx_wr SHALL be 1 for exactly one cycle; the next state is GUARD.
REQ-010 Handshake-to-tx_wr latency SHALL be exactly 1 cycle.
REQ-011 GUARD SHALL last exactly one cycle, absorbing the engine's tx_busy rise latency; the next state is DRAIN.
REQ-012 DRAIN SHALL remain until tx_busy=0, then return to IDLE.
REQ-013 If tx_busy never rose, DRAIN SHALL exit on the first cycle.
REQ-014 tx_data SHALL hold its value from LOAD until the next handshake.
REQ-015 Locking rules:
  - a handshake with req_last=0 SHALL set locked=1 with owner grant_id;
  - a handshake with req_last=1 SHALL clear locked.
REQ-016 While locked, in IDLE with the owner's req_valid=0, a timeout counter SHALL increment every cycle.
REQ-017 The timeout counter SHALL reset to 0 on any handshake or on leaving the lock.
REQ-018 When the counter reaches LOCK_TIMEOUT-1, the block SHALL:
  - clear locked;
  - pulse lock_drop for one cycle;
  - leave grant_id unchanged, so round-robin continues from the dropped owner.
REQ-019 At most one req_ready bit SHALL be 1 in any cycle.
REQ-020 A requester deasserting req_valid before its handshake SHALL lose nothing, and the arbiter re-evaluates every IDLE cycle.
REQ-021 A sole requester SHALL be served back-to-back, with one byte per UART character time.
REQ-022 tx_wr SHALL never be asserted while tx_busy=1 was sampled in the preceding IDLE cycle.

Reset
REQ-023 Reset SHALL force, on the next edge, state=IDLE and tx_wr=0.
REQ-024 Reset SHALL also force req_ready=0, tx_data=0 and grant_id=N_REQ-1, so the first search starts at 0.
REQ-025 Reset SHALL also force locked=0, lock_drop=0 and the timeout counter to 0.
REQ-026 Reset asserted in LOAD, GUARD or DRAIN SHALL abort the sequence with no further tx_wr; a byte already handed to the engine is not recalled.

Structure
REQ-027 The shared package uart_arb_pkg SHALL hold:
  - the state encodings (IDLE, LOAD, GUARD, DRAIN);
  - default N_REQ and LOCK_TIMEOUT;
  - the clog2 helper function.
REQ-028 Round-robin selection SHALL be a combinational sub-module rr_pick with these ports:
  - inputs: request vector, last-grant index, lock flag, owner index;
  - outputs: one-hot select and index.
REQ-029 The FSM, lock logic and timeout counter SHALL reside in uart_tx_arbiter.

Verification
REQ-030 The bench SHALL model the engine as tx_busy rising 1 cycle after tx_wr and staying high 10 cycles.
REQ-031 Scenario 1: after reset, req_valid=4'b0001, data 0x41, last=1 -> req_ready[0] pulses; next cycle tx_wr=1 with tx_data=0x41; grant_id=0.
REQ-032 Scenario 2: all four valid continuously, each byte last=1 -> grant order 0,1,2,3,0; no tx_wr while tx_busy=1.
REQ-033 Scenario 3: requester 2 sends 0x10,0x11 (last=0) then 0x12 (last=1) while requester 0 is valid -> bytes 0x10,0x11,0x12 are sent contiguously, then requester 0 is granted.
REQ-034 Scenario 4: requester 1 locks with last=0 then drops valid, LOCK_TIMEOUT=16 -> lock_drop pulses 16 IDLE cycles later, locked=0, then requester 2 is granted.
REQ-035 Scenario 5: reset asserted during GUARD -> next cycle state IDLE, tx_wr=0, locked=0, grant_id=N_REQ-1.
